jellyvl_etherneco_synctimer_master: RTL and testbench
=====================================================

Name: jellyvl_etherneco_synctimer_master

Overview:
- Ring-master side of the EtherNeco sync-timer protocol.
- Periodically builds and streams the timer command packet:
  - command byte
  - 64-bit master time
  - one 32-bit offset per slave node
- Captures each node's returned elapsed-time word from the response packet and derives the next offset table.
- Sits between the master's timer core (supplies current_time) and the ring packet transmitter/receiver.

Parameters:
- TIMER_WIDTH, 64: timer bit width; only the low 64 bits are transmitted.
- NODES, 4: number of slave nodes on the ring, 1..15.
- PERIOD_WIDTH, 32: width of the sync-period counter.
- TIMEOUT_CYCLES, 1000000: response timeout in clocks; used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  allows new sync cycles to start
- param_period  input  PERIOD_WIDTH  sync period in clocks, minus 1
- current_time  input  TIMER_WIDTH  master free-running time
- cmd_tx_length  output  16  packet payload length, constant 9+4*NODES
- m_cmd_first  output  1  first byte of payload
- m_cmd_last  output  1  last byte of payload
- m_cmd_pos  output  16  byte index
- m_cmd_data  output  8  payload byte
- m_cmd_valid  output  1  byte valid
- m_cmd_ready  input  1  transmitter accepts byte
- res_rx_start  input  1  response packet start pulse
- res_rx_end  input  1  response packet end pulse
- res_rx_error  input  1  response packet error pulse
- s_res_pos  input  16  response byte index
- s_res_data  input  8  response byte
- s_res_valid  input  1  response byte valid
- busy  output  1  state is not IDLE
- synced  output  1  at least one valid offset table has been computed
- overrun  output  1  one-cycle pulse: a period tick arrived while busy

Behaviour:
- All registers clear asynchronously on reset_n=0:
  - state=IDLE, period counter=0, pos=0
  - offsets=0, elapsed=0
  - synced=0, overrun=0, m_cmd_valid=0
  - m_cmd_first/last=0, m_cmd_data=0
- Period counter:
  - Increments every clock while enable=1.
  - Wraps to 0 at param_period and asserts tick.
  - enable=0 holds the counter at 0.
- State IDLE:
  - tick → SEND.
  - On that transition: capture tx_time=current_time[63:0] and start_time=current_time[31:0]; set pos=0.
- State SEND:
  - m_cmd_valid=1. Data, first and last are registered; they change only when valid&&ready, or on entry.
  - Byte map, multi-byte fields little-endian:
    - pos 0: cmd = {6'b0, ~synced, 1'b1}. Bit0 = correct_valid, bit1 = override.
    - pos 1..8: tx_time byte pos-1.
    - pos 9+4k+i: offset[k] byte i, for k=0..NODES-1, i=0..3.
  - m_cmd_first=1 at pos 0; m_cmd_last=1 at pos 8+4*NODES.
  - pos advances on valid&&ready.
  - Handshake on the last byte → WAIT_RES; m_cmd_valid drops the next cycle.
  - valid must not drop while ready=0 (standard hold rule).
- State WAIT_RES:
  - res_rx_start: total = current_time[31:0] − start_time, modulo 2^32.
  - s_res_valid at pos 9+4k+i writes elapsed[k] byte i. Other positions are ignored.
  - res_rx_end without res_rx_error in the same cycle → CALC, k=0.
  - res_rx_error at any point → IDLE; offsets, elapsed and synced are unchanged.
- State CALC:
  - One node per clock: offset[k] = (total − elapsed[k]) >> 1, unsigned 32-bit, truncating.
  - After k=NODES-1: synced=1 → IDLE.
  - Latency: NODES clocks after res_rx_end.
- Simultaneous and boundary events:
  - tick while state≠IDLE: tick dropped, overrun pulses for 1 clock.
  - tick and the CALC→IDLE transition in the same cycle: tick is dropped, counted as overrun.
  - enable deasserted mid-packet: the current cycle completes; no new one starts.
  - res_rx_start/end while not in WAIT_RES: ignored.
- Reset mid-packet: the stream is abandoned immediately (valid=0); the downstream transmitter must tolerate the truncated packet.

Optional Feature:
- JELLYVL_ETHERNECO_SYNCTIMER_MASTER_TIMEOUT_EN defined:
  - A counter runs in WAIT_RES.
  - On reaching TIMEOUT_CYCLES: → IDLE, synced cleared to 0, so the next command has override=1.
- Macro undefined: no counter; WAIT_RES waits indefinitely for res_rx_end or res_rx_error.

Decomposition:
- Package jellyvl_etherneco_synctimer_pkg, shared with the slave:
  - t_time (8×8 bits), t_offset (4×8 bits)
  - CMD_BIT_VALID=0, CMD_BIT_OVERRIDE=1
  - POS_CMD=0, POS_TIME=1, POS_OFFSET=9, OFFSET_BYTES=4
- Sub-module jellyvl_etherneco_synctimer_offset_table:
  - Elapsed/offset storage, byte-write port, sequential CALC datapath, byte read port for SEND.
- The FSM, period counter and stream stay in the top.

Test Plan:
- NODES=2, param_period=99, ready=1 → packet every 100 clocks; length 17; pos0=0x03 (unsynced); bytes 1..8 equal current_time at start; offsets all 0.
- Response with total=1000 and elapsed {0x00000190, 0x00000064} → after 2 clocks offsets {300, 450}; synced=1; next pos0=0x01; bytes 9..12 = 2C 01 00 00.
- Random ready backpressure (50%) → byte sequence identical to the ready=1 case; no byte skipped or duplicated; valid never drops early.
- res_rx_error mid-response → IDLE, offsets and synced unchanged, next packet identical in the offset field.
- param_period=9 with ready=0 held for 30 clocks → overrun pulses at each tick after the first; busy stays 1.
- TIMEOUT_EN with TIMEOUT_CYCLES=50 and no response → IDLE 50 clocks after the last byte; synced=0; next pos0=0x03.

Source files
------------

// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// jellyvl_etherneco_synctimer_pkg: shared types and packet layout for the EtherNeco sync-timer master and slave
package jellyvl_etherneco_synctimer_pkg;

    typedef logic [7:0][7:0] t_time;
    typedef logic [3:0][7:0] t_offset;

    localparam int          CMD_BIT_VALID    = 0;
    localparam int          CMD_BIT_OVERRIDE = 1;
    localparam logic [15:0] POS_CMD          = 16'd0;
    localparam logic [15:0] POS_TIME         = 16'd1;
    localparam logic [15:0] POS_OFFSET       = 16'd9;
    localparam int          OFFSET_BYTES     = 4;
    localparam int          NODE_BITS        = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RES,
        ST_CALC
    } t_state;

    function automatic logic [15:0] payload_length(input int nodes);
        return 16'(int'(POS_OFFSET) + OFFSET_BYTES * nodes);
    endfunction

endpackage

// File: rtl/jellyvl_etherneco_synctimer_offset_table.sv
// jellyvl_etherneco_synctimer_offset_table: per-node elapsed/offset storage with byte write, sequential offset calc and byte read
module jellyvl_etherneco_synctimer_offset_table
    import jellyvl_etherneco_synctimer_pkg::*;
#(
    parameter int NODES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_wr_en,
    input  logic [NODE_BITS-1:0] i_wr_node,
    input  logic [1:0]           i_wr_byte,
    input  logic [7:0]           i_wr_data,
    input  logic                 i_calc_en,
    input  logic [NODE_BITS-1:0] i_calc_node,
    input  logic [31:0]          i_total,
    input  logic [NODE_BITS-1:0] i_rd_node,
    input  logic [1:0]           i_rd_byte,
    output logic [7:0]           o_rd_data
);

    t_offset r_elapsed [NODES];
    t_offset r_offset  [NODES];

    // response bytes land in elapsed; the selected node's offset is half the unaccounted round trip
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NODES; k++) begin
                r_elapsed[k] <= '0;
                r_offset[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NODES; k++) begin
                if (i_wr_en && i_wr_node == NODE_BITS'(k)) r_elapsed[k][i_wr_byte] <= i_wr_data;
                if (i_calc_en && i_calc_node == NODE_BITS'(k)) r_offset[k] <= (i_total - r_elapsed[k]) >> 1;
            end
        end
    end

    // byte read port feeding the command stream
    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < NODES; k++) o_rd_data = (i_rd_node == NODE_BITS'(k)) ? r_offset[k][i_rd_byte] : o_rd_data;
    end

endmodule

// File: rtl/jellyvl_etherneco_synctimer_master.sv
// jellyvl_etherneco_synctimer_master: ring master that streams timer commands and derives slave offsets (optional response timeout: JELLYVL_ETHERNECO_SYNCTIMER_MASTER_TIMEOUT_EN)
module jellyvl_etherneco_synctimer_master
    import jellyvl_etherneco_synctimer_pkg::*;
#(
    parameter int TIMER_WIDTH    = 64,
    parameter int NODES          = 4,
    parameter int PERIOD_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] param_period,
    input  logic [TIMER_WIDTH-1:0]  current_time,
    output logic [15:0]             cmd_tx_length,
    output logic                    m_cmd_first,
    output logic                    m_cmd_last,
    output logic [15:0]             m_cmd_pos,
    output logic [7:0]              m_cmd_data,
    output logic                    m_cmd_valid,
    input  logic                    m_cmd_ready,
    input  logic                    res_rx_start,
    input  logic                    res_rx_end,
    input  logic                    res_rx_error,
    input  logic [15:0]             s_res_pos,
    input  logic [7:0]              s_res_data,
    input  logic                    s_res_valid,
    output logic                    busy,
    output logic                    synced,
    output logic                    overrun
);

    localparam logic [15:0] LEN = payload_length(NODES);

    if (NODES < 1 || NODES > 15) begin : g_bad_nodes
        $error("NODES must be 1..15");
    end
    if (TIMER_WIDTH < 64 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("TIMER_WIDTH must be >= 64 and TIMEOUT_CYCLES >= 1");
    end

    t_state                r_state;
    logic [PERIOD_WIDTH-1:0] r_count;
    logic [15:0]           r_pos;
    t_time                 r_tx_time;
    logic [31:0]           r_start_time;
    logic [31:0]           r_total;
    logic [NODE_BITS-1:0]  r_calc_node;
`ifdef JELLYVL_ETHERNECO_SYNCTIMER_MASTER_TIMEOUT_EN
    logic [31:0]           r_timeout;
`endif

    logic                  w_tick;
    logic                  w_handshake;
    logic [15:0]           w_sel_pos;
    logic [15:0]           w_sel_rel;
    logic [2:0]            w_time_idx;
    logic [7:0]            w_cmd;
    logic [7:0]            w_rd_data;
    logic [7:0]            w_tx_byte;
    logic [15:0]           w_res_rel;
    logic                  w_wr_en;

    assign cmd_tx_length = LEN;
    assign m_cmd_pos     = r_pos;
    assign busy          = (r_state != ST_IDLE);
    assign w_tick        = enable && (r_count == param_period);
    assign w_handshake   = m_cmd_valid && m_cmd_ready;
    assign w_sel_pos     = (r_state == ST_IDLE) ? POS_CMD : r_pos + 16'd1;
    assign w_sel_rel     = w_sel_pos - POS_OFFSET;
    assign w_time_idx    = 3'(w_sel_pos - POS_TIME);
    assign w_res_rel     = s_res_pos - POS_OFFSET;
    assign w_wr_en       = (r_state == ST_WAIT_RES) && s_res_valid && !res_rx_error
                           && (s_res_pos >= POS_OFFSET) && (s_res_pos < LEN);

    // byte that will be presented next: the entry byte in IDLE, otherwise the one after the current pos
    always_comb begin
        w_cmd                   = '0;
        w_cmd[CMD_BIT_VALID]    = 1'b1;
        w_cmd[CMD_BIT_OVERRIDE] = ~synced;
        w_tx_byte = (w_sel_pos == POS_CMD)   ? w_cmd :
                    (w_sel_pos <  POS_OFFSET) ? r_tx_time[w_time_idx] : w_rd_data;
    end

    jellyvl_etherneco_synctimer_offset_table #(
        .NODES(NODES)
    ) u_offset_table (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr_en    (w_wr_en),
        .i_wr_node  (NODE_BITS'(w_res_rel >> 2)),
        .i_wr_byte  (w_res_rel[1:0]),
        .i_wr_data  (s_res_data),
        .i_calc_en  (r_state == ST_CALC),
        .i_calc_node(r_calc_node),
        .i_total    (r_total),
        .i_rd_node  (NODE_BITS'(w_sel_rel >> 2)),
        .i_rd_byte  (w_sel_rel[1:0]),
        .o_rd_data  (w_rd_data)
    );

    // sync-period counter; held at zero while disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_count <= '0;
        else          r_count <= (!enable || w_tick) ? '0 : r_count + PERIOD_WIDTH'(1);
    end

    // protocol FSM: stream command, collect response, compute offsets one node per clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pos        <= '0;
            r_tx_time    <= '0;
            r_start_time <= '0;
            r_total      <= '0;
            r_calc_node  <= '0;
            synced       <= 1'b0;
            overrun      <= 1'b0;
            m_cmd_valid  <= 1'b0;
            m_cmd_first  <= 1'b0;
            m_cmd_last   <= 1'b0;
            m_cmd_data   <= '0;
`ifdef JELLYVL_ETHERNECO_SYNCTIMER_MASTER_TIMEOUT_EN
            r_timeout    <= '0;
`endif
        end else begin
            overrun <= w_tick && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state      <= ST_SEND;
                        r_tx_time    <= current_time[63:0];
                        r_start_time <= current_time[31:0];
                        r_pos        <= POS_CMD;
                        m_cmd_valid  <= 1'b1;
                        m_cmd_first  <= 1'b1;
                        m_cmd_last   <= 1'b0;
                        m_cmd_data   <= w_tx_byte;
                    end
                end
                ST_SEND: begin
                    if (w_handshake && m_cmd_last) begin
                        r_state     <= ST_WAIT_RES;
                        m_cmd_valid <= 1'b0;
                        m_cmd_first <= 1'b0;
                        m_cmd_last  <= 1'b0;
`ifdef JELLYVL_ETHERNECO_SYNCTIMER_MASTER_TIMEOUT_EN
                        r_timeout   <= '0;
`endif
                    end else if (w_handshake) begin
                        r_pos       <= w_sel_pos;
                        m_cmd_data  <= w_tx_byte;
                        m_cmd_first <= 1'b0;
                        m_cmd_last  <= (w_sel_pos == LEN - 16'd1);
                    end
                end
                ST_WAIT_RES: begin
                    if (res_rx_start) r_total <= current_time[31:0] - r_start_time;
                    if (res_rx_error) begin
                        r_state <= ST_IDLE;
                    end else if (res_rx_end) begin
                        r_state     <= ST_CALC;
                        r_calc_node <= '0;
                    end
`ifdef JELLYVL_ETHERNECO_SYNCTIMER_MASTER_TIMEOUT_EN
                    else if (r_timeout == 32'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                        synced  <= 1'b0;
                    end else begin
                        r_timeout <= r_timeout + 32'd1;
                    end
`endif
                end
                ST_CALC: begin
                    r_calc_node <= r_calc_node + NODE_BITS'(1);
                    if (r_calc_node == NODE_BITS'(NODES - 1)) begin
                        r_state <= ST_IDLE;
                        synced  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_master.sv
// tb_jellyvl_etherneco_synctimer_master: randomized self-checking bench against a packet-level reference model
module tb_jellyvl_etherneco_synctimer_master;

    localparam int NODES = 2;
    localparam int LEN   = 9 + 4 * NODES;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] param_period = 32'd99;
    logic [63:0] current_time = '0;
    logic [15:0] cmd_tx_length;
    logic        m_cmd_first, m_cmd_last, m_cmd_valid;
    logic        m_cmd_ready = 1'b1;
    logic [15:0] m_cmd_pos;
    logic [7:0]  m_cmd_data;
    logic        res_rx_start = 1'b0, res_rx_end = 1'b0, res_rx_error = 1'b0;
    logic [15:0] s_res_pos = '0;
    logic [7:0]  s_res_data = '0;
    logic        s_res_valid = 1'b0;
    logic        busy, synced, overrun;

    jellyvl_etherneco_synctimer_master #(
        .TIMER_WIDTH(64), .NODES(NODES), .PERIOD_WIDTH(32), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .param_period(param_period),
        .current_time(current_time), .cmd_tx_length(cmd_tx_length),
        .m_cmd_first(m_cmd_first), .m_cmd_last(m_cmd_last), .m_cmd_pos(m_cmd_pos),
        .m_cmd_data(m_cmd_data), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .res_rx_start(res_rx_start), .res_rx_end(res_rx_end), .res_rx_error(res_rx_error),
        .s_res_pos(s_res_pos), .s_res_data(s_res_data), .s_res_valid(s_res_valid),
        .busy(busy), .synced(synced), .overrun(overrun)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          bp = 1'b0;
    bit          rdy = 1'b1;
    bit          m_synced = 1'b0;
    logic [31:0] m_off [NODES];
    logic [7:0]  got [64];
    logic [7:0]  pkt_bytes [64];
    logic [63:0] cur_time, pkt_time, last_start;
    int          nbytes = 0;
    int          pkt_done = 0;
    int          pkt_end_cyc = 0;
    bit          prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0]  prev_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        current_time <= current_time + 64'd1;
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got_v, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int p);
        if (p == 0) return {6'b0, ~m_synced, 1'b1};
        if (p < 9) return pkt_time[8*(p-1) +: 8];
        return m_off[(p-9)/4][8*((p-9)%4) +: 8];
    endfunction

    task automatic compare_packet();
        for (int i = 0; i < LEN; i++) check("pkt_byte", pkt_bytes[i], exp_byte(i));
    endtask

    // stream monitor: collects accepted bytes and enforces the valid/ready hold rule
    always @(negedge clk) begin
        if (reset_n) begin
            if (m_cmd_valid && !prev_valid) begin
                cur_time = current_time - 64'd1;
                nbytes = 0;
                check("first_on_start", m_cmd_first, 1);
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", m_cmd_valid, 1);
                check("hold_data", m_cmd_data, prev_data);
            end
            if (m_cmd_valid && m_cmd_ready) begin
                check("pos", m_cmd_pos, nbytes);
                check("first", m_cmd_first, nbytes == 0);
                check("last", m_cmd_last, nbytes == LEN - 1);
                if (nbytes < 64) got[nbytes] = m_cmd_data;
                nbytes++;
                if (m_cmd_last) begin
                    pkt_time = cur_time;
                    pkt_bytes = got;
                    pkt_end_cyc = cyc;
                    pkt_done++;
                end
            end
        end
        prev_valid = m_cmd_valid;
        prev_ready = m_cmd_ready;
        prev_data  = m_cmd_data;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_cmd_ready = bp ? 1'($urandom % 2) : rdy;
        end
    end

    task automatic wait_packet();
        int start_cnt = pkt_done;
        int n = 0;
        while (pkt_done == start_cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (pkt_done == start_cnt) check("pkt_arrive_timeout", n, 0);
    endtask

    task automatic send_response(input logic [31:0] total, input logic [31:0] e0, input logic [31:0] e1, input bit err);
        logic [31:0] el [2];
        int n = 0;
        int err_pos = $urandom_range(2, 15);
        el[0] = e0;
        el[1] = e1;
        @(posedge clk); #1;
        while ((current_time[31:0] - pkt_time[31:0]) != total && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) check("res_align_timeout", n, 0);
        res_rx_start = 1'b1;
        @(posedge clk); #1;
        res_rx_start = 1'b0;
        for (int p = 0; p < LEN; p++) begin
            if ($urandom % 4 == 0) begin
                s_res_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_res_pos   = 16'(p);
            s_res_data  = (p >= 9) ? el[(p-9)/4][8*((p-9)%4) +: 8] : 8'($urandom);
            s_res_valid = 1'b1;
            res_rx_error = err && (p == err_pos);
            @(posedge clk); #1;
            res_rx_error = 1'b0;
            if (err && p == err_pos) break;
        end
        s_res_valid = 1'b0;
        res_rx_end = !err;
        @(posedge clk); #1;
        res_rx_end = 1'b0;
        if (!err) begin
            m_off[0] = (total - e0) >> 1;
            m_off[1] = (total - e1) >> 1;
            m_synced = 1'b1;
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("synced_after_res", synced, m_synced);
    endtask

    initial begin
        int n;
        current_time = {$urandom, $urandom};
        m_off[0] = '0;
        m_off[1] = '0;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", m_cmd_valid, 0);
        check("rst_first", m_cmd_first, 0);
        check("rst_last", m_cmd_last, 0);
        check("rst_data", m_cmd_data, 0);
        check("rst_pos", m_cmd_pos, 0);
        check("rst_busy", busy, 0);
        check("rst_synced", synced, 0);
        check("rst_overrun", overrun, 0);
        check("tx_length", cmd_tx_length, LEN);
        @(posedge clk); #1;
        reset_n = 1'b1;
        enable = 1'b1;

        // unsynced first packet, offsets zero
        wait_packet();
        compare_packet();
        check("cmd_unsynced", pkt_bytes[0], 8'h03);
        last_start = pkt_time;

        // known response: total 1000, elapsed 400 / 100 -> offsets 300 / 450
        send_response(32'd1000, 32'h190, 32'h64, 1'b0);
        wait_packet();
        compare_packet();
        check("cmd_synced", pkt_bytes[0], 8'h01);
        check("off0_300", {pkt_bytes[12], pkt_bytes[11], pkt_bytes[10], pkt_bytes[9]}, 32'd300);
        check("off1_450", {pkt_bytes[16], pkt_bytes[15], pkt_bytes[14], pkt_bytes[13]}, 32'd450);
        check("period_align", (pkt_time - last_start) % 100, 0);
        last_start = pkt_time;

        // randomized rounds with backpressure and occasional response errors
        bp = 1'b1;
        for (int it = 0; it < 8; it++) begin
            send_response($urandom_range(120, 300), $urandom, $urandom, ($urandom % 4) == 0);
            if (it == 7) break;
            wait_packet();
            compare_packet();
            check("period_align", (pkt_time - last_start) % 100, 0);
            last_start = pkt_time;
        end

        // overrun: short period with the transmitter stalled
        @(posedge clk); #1;
        enable = 1'b0;
        bp = 1'b0;
        rdy = 1'b0;
        param_period = 32'd9;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
        n = 0;
        repeat (45) begin
            @(negedge clk);
            if (overrun) n++;
        end
        check("overrun_count", n, 3);
        check("busy_held", busy, 1);
        @(posedge clk); #1;
        enable = 1'b0;
        rdy = 1'b1;
        wait_packet();
        compare_packet();
        send_response(32'd150, $urandom, $urandom, 1'b1);

        // response strobes outside WAIT_RES are ignored
        @(posedge clk); #1;
        res_rx_start = 1'b1;
        res_rx_end = 1'b1;
        @(posedge clk); #1;
        res_rx_start = 1'b0;
        res_rx_end = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_end_idle", busy, 0);
        end
        check("stray_end_synced", synced, m_synced);

`ifdef JELLYVL_ETHERNECO_SYNCTIMER_MASTER_TIMEOUT_EN
        param_period = 32'd999;
        @(posedge clk); #1;
        enable = 1'b1;
        wait_packet();
        compare_packet();
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", cyc - pkt_end_cyc, 50);
        check("timeout_synced", synced, 0);
        m_synced = 1'b0;
        wait_packet();
        compare_packet();
        check("timeout_cmd", pkt_bytes[0], 8'h03);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
